// File: rtl/imem_loader_pkg.sv
// Shared state encoding and byte/header constants for the instruction-memory loader.
// Build option: LOADER_CHECKSUM_EN widens the state type to make room for the CHK state.
package imem_loader_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned HDR_BYTES = 2;
    localparam int unsigned CNT_W     = HDR_BYTES * BYTE_W;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [3:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        DONE,
        ERR,
        CHK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        DONE,
        ERR
    } state_t;
`endif

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles consecutive bytes into a big-endian 16-bit word; word_valid_o pulses
// for one cycle after the low byte is taken, with word_o held stable until the next high byte.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [CNT_W-1:0]  word_o,
    output logic              word_valid_o
);

    logic [CNT_W-1:0] word_q, word_d;
    logic             phase_q, phase_d;
    logic             valid_q, valid_d;

    always_comb begin
        word_d  = word_q;
        phase_d = phase_q;
        valid_d = 1'b0;
        if (clr_i) begin
            phase_d = 1'b0;
        end else if (byte_valid_i) begin
            if (!phase_q) begin
                word_d[CNT_W-1:BYTE_W] = byte_i;
                phase_d                = 1'b1;
            end else begin
                word_d[BYTE_W-1:0] = byte_i;
                phase_d            = 1'b0;
                valid_d            = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            phase_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: byte stream -> 16-bit big-endian instruction words, core held until done.
// Build option: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte checked in state CHK.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    // Full depth (N == 2**ADDR_W) is legal, so the limit needs one bit more than the count.
    localparam logic [CNT_W:0] DEPTH = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t LAST_ST = CHK;
    logic [BYTE_W-1:0] sum_q, sum_d;
`else
    localparam state_t LAST_ST = DONE;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic              pk_clr, pk_valid;
    logic [CNT_W-1:0]  pk_word;
    logic              pk_word_valid;
    logic [CNT_W-1:0]  n_hdr;

    assign n_hdr = {count_q[CNT_W-1:BYTE_W], in_data};

    imem_byte_packer u_packer (
        .clk          (clk),
        .rst_n        (rst),
        .clr_i        (pk_clr),
        .byte_valid_i (pk_valid),
        .byte_i       (in_data),
        .word_o       (pk_word),
        .word_valid_o (pk_word_valid)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addr_d   = addr_q;
        in_ready = 1'b0;
        pk_clr   = 1'b0;
        pk_valid = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = HDR_HI;
                    addr_d  = '0;
                    pk_clr  = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    count_d[CNT_W-1:BYTE_W] = in_data;
                    state_d                 = HDR_LO;
                end
            end
            HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    count_d = n_hdr;
                    if (n_hdr == '0)
                        state_d = LAST_ST;
                    else if ({1'b0, n_hdr} > DEPTH)
                        state_d = ERR;
                    else
                        state_d = DAT_HI;
                end
            end
            DAT_HI, DAT_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pk_valid = 1'b1;
                    state_d  = (state_q == DAT_HI) ? DAT_LO : WRITE;
`ifdef LOADER_CHECKSUM_EN
                    sum_d    = sum_q ^ in_data;
`endif
                end
            end
            WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                count_d = count_q - CNT_W'(1);
                state_d = (count_q == CNT_W'(1)) ? LAST_ST : DAT_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_d = (in_data == sum_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Status flags follow the next state so they are valid the cycle a terminal state is entered.
    always_comb begin
        done_d = (state_d == DONE);
        err_d  = (state_d == ERR);
        hold_d = (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign mem_we    = pk_word_valid;
    assign mem_addr  = addr_q;
    assign mem_wdata = pk_word;
    assign cpu_hold  = hold_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load scenarios plus hand-written corner sequences,
// with memory writes checked against a scoreboard queue filled as the byte stream is driven.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int unsigned ADDR_W = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic [15:0] hdr;
        int unsigned nsend;
        bit          stall;
        bit          basic;
        bit          exp_done;
        bit          exp_err;
        logic [7:0]  exp_addr;
        int unsigned exp_writes;
    } row_t;

    exp_t        sb[$];
    exp_t        mon_e;
    row_t        rows[7];
    logic [15:0] wbuf[300];
    int          tests   = 0;
    int          fails   = 0;
    int          wr_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the oldest expected write, on its due cycle.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_we === 1'b1) begin
            wr_seen++;
            chk("ready_low_in_write", {31'b0, in_ready}, 32'd0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", mem_addr, mem_wdata);
            end else begin
                mon_e = sb.pop_front();
                chk("write_addr", {24'b0, mem_addr}, {24'b0, mon_e.addr});
                chk("write_data", {16'b0, mem_wdata}, {16'b0, mon_e.data});
                chk("write_cycle", cyc, mon_e.due);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (stall && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                #1;
                if (in_ready) return;
            end
        end
        tests++;
        fails++;
        $display("FAIL send_timeout: byte 0x%0h not accepted within 1000 cycles", b);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_hold", {31'b0, cpu_hold}, 32'd1);
        chk("start_done_clr", {31'b0, done}, 32'd0);
        chk("start_err_clr", {31'b0, err}, 32'd0);
        chk("start_addr_clr", {24'b0, mem_addr}, 32'd0);
    endtask

    task automatic run_load(input logic [15:0] hdr, input int unsigned nsend, input bit stall,
                            input bit with_chk, input bit bad_chk, input bit mid_start);
        logic [7:0] x;
        x       = 8'h00;
        wr_seen = 0;
        pulse_start();
        send_byte(hdr[15:8], stall);
        send_byte(hdr[7:0], stall);
        for (int unsigned i = 0; i < nsend; i++) begin
            send_byte(wbuf[i][15:8], stall);
            if (mid_start && i == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send_byte(wbuf[i][7:0], stall);
            sb.push_back('{addr: i[7:0], data: wbuf[i], due: cyc + 1});
            x = x ^ wbuf[i][15:8] ^ wbuf[i][7:0];
        end
        if (CHK_EN && with_chk)
            send_byte(bad_chk ? (x ^ 8'h01) : x, stall);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_end(input string name);
        for (int t = 0; t < 50; t++) begin
            if (done === 1'b1 || err === 1'b1) return;
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL %s_timeout: done/err not raised within 50 cycles", name);
    endtask

    task automatic check_end(input string name, input bit e_done, input bit e_err,
                             input logic [7:0] e_addr, input int e_writes);
        chk({name, "_done"}, {31'b0, done}, {31'b0, e_done});
        chk({name, "_err"}, {31'b0, err}, {31'b0, e_err});
        chk({name, "_hold"}, {31'b0, cpu_hold}, {31'b0, ~e_done});
        chk({name, "_ready"}, {31'b0, in_ready}, 32'd0);
        chk({name, "_addr"}, {24'b0, mem_addr}, {24'b0, e_addr});
        chk({name, "_writes"}, wr_seen, e_writes);
        chk({name, "_sb_empty"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_ready"}, {31'b0, in_ready}, 32'd0);
        chk({name, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({name, "_addr"}, {24'b0, mem_addr}, 32'd0);
        chk({name, "_wdata"}, {16'b0, mem_wdata}, 32'd0);
        chk({name, "_hold"}, {31'b0, cpu_hold}, 32'd1);
        chk({name, "_done"}, {31'b0, done}, 32'd0);
        chk({name, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hA5;

        //            hdr      nsend stall basic done err addr   writes
        rows[0] = '{16'h0003, 3,   1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 3};
        rows[1] = '{16'h0003, 3,   1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 3};
        rows[2] = '{16'h0000, 0,   1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 0};
        rows[3] = '{16'h0005, 5,   1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 5};
        rows[4] = '{16'h0100, 256, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 256};
        rows[5] = '{16'h0101, 0,   1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 0};
        rows[6] = '{16'h0001, 1,   1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 1};

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'b0, in_ready}, 32'd0);

        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < 300; i++)
                wbuf[i] = 16'(i * 16'h0137) ^ 16'h5A3C ^ 16'(r);
            if (rows[r].basic) begin
                wbuf[0] = 16'h1234;
                wbuf[1] = 16'hABCD;
                wbuf[2] = 16'h00FF;
            end
            run_load(rows[r].hdr, rows[r].nsend, rows[r].stall, !rows[r].exp_err, 1'b0, 1'b0);
            wait_end($sformatf("row%0d", r));
            check_end($sformatf("row%0d", r), rows[r].exp_done, rows[r].exp_err,
                      rows[r].exp_addr, rows[r].exp_writes);
        end

        // A start pulse while the low data byte is awaited must not restart the load.
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'h5678;
        run_load(16'h0002, 2, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_end("mid_start");
        check_end("mid_start", 1'b1, 1'b0, 8'd2, 2);

        // Reset after one and a half words: outputs drop back asynchronously.
        wr_seen = 0;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        sb.push_back('{addr: 8'h00, data: 16'h1234, due: cyc + 1});
        send_byte(8'hAB, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        chk("mid_reset_writes", wr_seen, 32'd1);
        chk("mid_reset_sb_empty", sb.size(), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("after_reset");

`ifdef LOADER_CHECKSUM_EN
        wbuf[0] = 16'h1234;
        run_load(16'h0001, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_end("chk_good");
        check_end("chk_good", 1'b1, 1'b0, 8'd1, 1);
        run_load(16'h0001, 1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_end("chk_bad");
        check_end("chk_bad", 1'b0, 1'b1, 8'd1, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader: the writer side of the instruction-memory interface the RISC_16 core fetches from. Accepts a byte stream (valid/ready), assembles 16-bit big-endian instruction words and writes them sequentially into instruction memory from address 0. Holds the core in reset (cpu_hold) until a complete image is written, then releases it. Sits beside RISC_16_top; drives the memory write port and the core's reset gate.

Parameters:
ADDR_W, 8, instruction-memory address width; depth = 2**ADDR_W words
DATA_W, 16, instruction word width; fixed at 16 (two bytes per word)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a (re)load
in_valid  in  1  byte-stream valid
in_data  in  8  byte-stream data
in_ready  out  1  loader can accept a byte this cycle
mem_we  out  1  instruction-memory write strobe, one cycle per word
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
cpu_hold  out  1  1 = hold core in reset
done  out  1  image loaded; level until next start
err  out  1  load aborted; level until next start

Behaviour:
- Reset (rst=0, async): state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, err=0.
- Byte transfer occurs only on the rising edge where in_valid&&in_ready. in_data is sampled only on that edge.
- States: IDLE, HDR_HI, HDR_LO, DAT_HI, DAT_LO, WRITE, DONE, ERR.
- IDLE/DONE/ERR: in_ready=0. On start: go to HDR_HI next cycle; clear done, err, mem_addr; set cpu_hold=1. In every other state, start is ignored.
- HDR_HI/HDR_LO: in_ready=1; capture word count N (high byte first) into a 16-bit count register.
- After HDR_LO: N=0 -> DONE. N>2**ADDR_W -> ERR. Otherwise -> DAT_HI.
- DAT_HI/DAT_LO: in_ready=1; the high byte goes to wdata[15:8], the low byte to wdata[7:0].
- WRITE: entered the cycle after the DAT_LO transfer. mem_we=1 for exactly one cycle with mem_addr/mem_wdata stable; in_ready=0. On exit, mem_addr increments by 1 and N decrements by 1. Remaining=0 -> DONE, else -> DAT_HI.
- Throughput: at most 1 word per 3 cycles.
- DONE: cpu_hold=0 and done=1, registered and asserted the cycle the state is entered. mem_addr holds the word count, or 0 after a full-depth wrap.
- ERR: err=1 and cpu_hold=1. Memory contents are undefined.
- Full depth: N=2**ADDR_W writes addresses 0..2**ADDR_W-1, after which mem_addr wraps to 0. This is legal.
- Stalls: in_valid low in any accepting state means wait indefinitely, with no timeout.
- Reset mid-load: immediate return to reset values. Partially written memory is not cleared.

Optional Feature:
LOADER_CHECKSUM_EN.
- Defined: after the last WRITE, add state CHK (in_ready=1), which accepts one byte. If that byte equals the XOR of all data bytes (header excluded) -> DONE; else -> ERR. With N=0 the expected checksum is 0x00 and CHK is still entered.
- Undefined: no CHK state; the stream ends after the last data byte.

Decomposition:
- Shared package holds:
  - the state encoding typedef/localparams (3-bit, or 4-bit with CHK);
  - BYTE_W=8;
  - the header-length constant (2 bytes).
- One natural sub-module is imem_byte_packer: a byte -> 16-bit word assembler with a hi/lo phase flag and a word_valid pulse. The FSM and counters stay in the top.

Test Plan:
- Reset value check: rst low with in_valid=1 -> in_ready=0, cpu_hold=1, mem_we=0, done=0, err=0.
- Basic load: start, then stream 00 03 12 34 AB CD 00 FF (in_valid held high) -> exactly three mem_we pulses: (0,0x1234), (1,0xABCD), (2,0x00FF). Then done=1, cpu_hold=0, mem_addr=3. Each pulse lands one cycle after its low byte.
- Backpressure/stall: same image with in_valid toggled in a random pattern -> identical writes, and no byte is consumed while in_ready=0 (WRITE cycles).
- Boundaries: header 00 00 -> DONE with no writes. With ADDR_W=8, header 01 00 plus 256 words -> writes to 0..255 and mem_addr wraps to 0. Header 01 01 -> ERR, err=1, cpu_hold=1, no writes.
- Reset and restart: assert rst after 1.5 words -> outputs return to reset values immediately. A start while in DAT_LO is ignored. A start from DONE reloads and raises cpu_hold the next cycle.
- Checksum (LOADER_CHECKSUM_EN defined): 00 01 12 34 26 -> DONE. The same image ending in 27 -> ERR with cpu_hold=1.
